rx_sequencer: RTL and testbench

- Owns the single serial receiver and sequences it through start/busy handshakes.
- Program load: after a load request, receives program bytes, keeps only Brainfuck opcode characters, writes them into instruction memory, and closes the program with a 0x00 halt word.
- Run phase: serves the CPU's `,` input requests from the same receiver.
- Sits between the receiver, the instruction memory write port and the CPU input port.

---
 rtl/rx_sequencer.sv | 166 ++++++++++++++++
 tb/tb_rx_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sequencer.sv
// rx_sequencer: owns the serial receiver and sequences it through start/busy handshakes.
// A load request pulls bytes from the receiver, keeps only Brainfuck opcodes, writes them to
// instruction memory and closes the program with a 0x00 halt word. In the run phase the same
// receiver serves the CPU's ',' input requests.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   load_start               one-cycle (re)load request
//   rx_start / rx_busy       receive request to / busy flag from the receiver
//   rx_data                  received byte, valid once rx_busy has fallen
//   imem_we/addr/wdata       instruction memory write port
//   cpu_in_req               CPU input request (level)
//   cpu_in_ack / cpu_in_data one-cycle ack and the delivered byte (held)
//   loading / prog_ready     phase indicators
//   overflow / prog_len      result of the last load
module rx_sequencer #(
  parameter int unsigned ADDR_W     = 12,
  parameter logic [7:0]  TERMINATOR = 8'h21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  output logic              rx_start,
  input  logic              rx_busy,
  input  logic [7:0]        rx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  input  logic              cpu_in_req,
  output logic              cpu_in_ack,
  output logic [7:0]        cpu_in_data,
  output logic              loading,
  output logic              prog_ready,
  output logic              overflow,
  output logic [ADDR_W-1:0] prog_len
);

  typedef enum logic [3:0] {
    StIdle, StLArm, StLWait, StLWrite, StLTerm, StRun, StCArm, StCWait, StCDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        cpu_data_q, cpu_data_d;
  logic              ovf_q, ovf_d;
  logic              pend_q, pend_d;

  function automatic logic is_opcode(input logic [7:0] b);
    case (b)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_opcode = 1'b1;
      default:                                                is_opcode = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    byte_d     = byte_q;
    cpu_data_d = cpu_data_q;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    ptr_inc    = ptr_q + ADDR_W'(1);

    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          ptr_d   = '0;
          ovf_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = StLArm;
        end
      end
      // rx_busy low here means the receiver has not started yet, not that it finished.
      StLArm: begin
        if (rx_busy) state_d = StLWait;
      end
      StLWait: begin
        if (!rx_busy) begin
          byte_d = rx_data;
          if (rx_data == TERMINATOR)  state_d = StLTerm;
          else if (is_opcode(rx_data)) state_d = StLWrite;
          else                         state_d = StLArm;
        end
      end
      StLWrite: begin
        ptr_d = ptr_inc;
        // The last slot is kept for the halt word, so stop one short of full.
        if (&ptr_inc) begin
          ovf_d   = 1'b1;
          state_d = StLTerm;
        end else begin
          state_d = StLArm;
        end
      end
      StLTerm: begin
        len_d   = ptr_q;
        state_d = StRun;
      end
      StRun: begin
        if (load_start || pend_q) begin
          ptr_d   = '0;
          ovf_d   = 1'b0;
          pend_d  = 1'b0;
          state_d = StLArm;
        end else if (cpu_in_req) begin
          state_d = StCArm;
        end
      end
      // A load request during a CPU transfer is remembered and served from RUN.
      StCArm: begin
        if (load_start) pend_d = 1'b1;
        if (rx_busy)    state_d = StCWait;
      end
      StCWait: begin
        if (load_start) pend_d = 1'b1;
        if (!rx_busy) begin
          cpu_data_d = rx_data;
          state_d    = StCDone;
        end
      end
      StCDone: begin
        if (load_start) pend_d = 1'b1;
        state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      len_q      <= '0;
      byte_q     <= 8'h00;
      cpu_data_q <= 8'h00;
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      byte_q     <= byte_d;
      cpu_data_q <= cpu_data_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
    end
  end

  // Outputs are registers or decodes of the registered state only.
  assign rx_start    = (state_q == StLArm) || (state_q == StCArm);
  assign imem_we     = (state_q == StLWrite) || (state_q == StLTerm);
  assign imem_addr   = imem_we ? ptr_q : '0;
  assign imem_wdata  = (state_q == StLWrite) ? byte_q : 8'h00;
  assign cpu_in_ack  = (state_q == StCDone);
  assign cpu_in_data = cpu_data_q;
  assign loading     = (state_q == StLArm) || (state_q == StLWait) ||
                       (state_q == StLWrite) || (state_q == StLTerm);
  assign prog_ready  = (state_q == StRun) || (state_q == StCArm) ||
                       (state_q == StCWait) || (state_q == StCDone);
  assign overflow    = ovf_q;
  assign prog_len    = len_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// Self-checking bench for rx_sequencer: a behavioural receiver feeds byte streams, a reference
// model derives the expected memory image, length, overflow and bytes consumed.
module tb_rx_sequencer;

  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [7:0]  TERM  = 8'h21;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          rx_start;
  logic          rx_busy;
  logic [7:0]    rx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_wdata;
  logic          cpu_in_req = 1'b0;
  logic          cpu_in_ack;
  logic [7:0]    cpu_in_data;
  logic          loading;
  logic          prog_ready;
  logic          overflow;
  logic [AW-1:0] prog_len;

  always #5 clk = ~clk;

  rx_sequencer #(.ADDR_W(AW), .TERMINATOR(TERM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .rx_start   (rx_start),
    .rx_busy    (rx_busy),
    .rx_data    (rx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_in_req (cpu_in_req),
    .cpu_in_ack (cpu_in_ack),
    .cpu_in_data(cpu_in_data),
    .loading    (loading),
    .prog_ready (prog_ready),
    .overflow   (overflow),
    .prog_len   (prog_len)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- receiver model ----------------
  logic [7:0] rx_q[$];
  int         rx_rd = 0;
  int         rx_skip_to = 0;
  int         n_starve = 0;

  initial begin
    int   cnt;
    bit   armed;
    logic [7:0] cur;
    cnt = 0; armed = 0; cur = 8'h00;
    rx_busy = 1'b0;
    rx_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        rx_busy = 1'b0; cnt = 0; armed = 0;
      end else if (rx_busy) begin
        cnt--;
        if (cnt == 0) begin
          rx_busy = 1'b0;
          rx_data = cur;
        end
      end else if (armed) begin
        // busy rises one cycle after the start request was seen
        armed = 0;
        rx_busy = 1'b1;
        cnt = $urandom_range(4, 2);
        if (rx_rd < rx_skip_to) rx_rd = rx_skip_to;
        if (rx_rd < rx_q.size()) begin
          cur = rx_q[rx_rd];
          rx_rd++;
        end else begin
          cur = 8'h00;
          n_starve++;
        end
        rx_data = ~cur;  // garbage until the frame completes
      end else if (rx_start) begin
        armed = 1;
      end
    end
  end

  // ---------------- monitors ----------------
  int wr_log[$];
  int ack_cnt = 0;
  int start_cnt = 0;
  logic [7:0] ack_data = 8'h00;

  always @(negedge clk) begin
    if (imem_we) wr_log.push_back((int'(imem_addr) << 8) | int'(imem_wdata));
    if (cpu_in_ack) begin
      ack_cnt  <= ack_cnt + 1;
      ack_data <= cpu_in_data;
    end
    if (rx_start) start_cnt <= start_cnt + 1;
  end

  // ---------------- reference model ----------------
  logic [7:0] cur_s[$];
  int         exp_wr[$];
  int         exp_consumed;
  int         exp_len;
  bit         exp_ovf;

  function automatic bit is_bf(input logic [7:0] b);
    string ops = "+-<>[].,";
    for (int i = 0; i < ops.len(); i++) if (b == ops[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_load();
    int ptr = 0;
    exp_wr.delete();
    exp_ovf = 0;
    exp_consumed = 0;
    for (int i = 0; i < cur_s.size(); i++) begin
      exp_consumed++;
      if (cur_s[i] == TERM) break;
      if (is_bf(cur_s[i])) begin
        exp_wr.push_back((ptr << 8) | int'(cur_s[i]));
        ptr++;
        if (ptr == DEPTH - 1) begin
          exp_ovf = 1;
          break;
        end
      end
    end
    exp_wr.push_back(ptr << 8);
    exp_len = ptr;
  endtask

  task automatic set_str(input string s);
    cur_s.delete();
    for (int i = 0; i < s.len(); i++) cur_s.push_back(s[i]);
  endtask

  task automatic rand_stream();
    string ops = "+-<>[].,";
    int len = $urandom_range(12, 1);
    cur_s.delete();
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(1, 0) == 1) cur_s.push_back(ops[$urandom_range(7, 0)]);
      else cur_s.push_back(8'($urandom_range(255, 0)));
    end
    cur_s.push_back(TERM);
  endtask

  task automatic flush_rx();
    rx_skip_to = rx_q.size();
  endtask

  // Queues cur_s behind any bytes already pending; returns its start index.
  task automatic push_stream(output int sstart);
    model_load();
    sstart = rx_q.size();
    foreach (cur_s[i]) rx_q.push_back(cur_s[i]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pulse_load();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!prog_ready && k < 2000);
    check({tag, "_ready"}, prog_ready, 1);
  endtask

  task automatic wait_ack(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpu_in_ack && k < 500);
    check({tag, "_ack_seen"}, cpu_in_ack, 1);
    cpu_in_req = 1'b0;
  endtask

  task automatic finish_load(input string tag, input int base, input int sstart);
    int n;
    wait_ready(tag);
    n = wr_log.size() - base;
    check({tag, "_nwr"}, n, exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < n; i++) check({tag, "_wr"}, wr_log[base + i], exp_wr[i]);
    check({tag, "_len"}, prog_len, exp_len);
    check({tag, "_ovf"}, overflow, exp_ovf);
    check({tag, "_used"}, rx_rd - sstart, exp_consumed);
  endtask

  task automatic do_load(input string tag);
    int base, sstart;
    flush_rx();
    push_stream(sstart);
    base = wr_log.size();
    pulse_load();
    check({tag, "_loading"}, loading, 1);
    finish_load(tag, base, sstart);
  endtask

  task automatic cpu_xfer(input string tag, input logic [7:0] b);
    int a0, base;
    flush_rx();
    rx_q.push_back(b);
    a0 = ack_cnt;
    base = wr_log.size();
    @(negedge clk); cpu_in_req = 1'b1;
    wait_ack(tag);
    repeat (3) @(negedge clk);
    check({tag, "_data"}, ack_data, b);
    check({tag, "_nack"}, ack_cnt - a0, 1);
    check({tag, "_nwr"}, wr_log.size() - base, 0);
    check({tag, "_ready"}, prog_ready, 1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rx_start"}, rx_start, 0);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_ack"}, cpu_in_ack, 0);
    check({tag, "_cdata"}, cpu_in_data, 0);
    check({tag, "_loading"}, loading, 0);
    check({tag, "_ready"}, prog_ready, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_len"}, prog_len, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, sstart, a0, s0, k;
    logic [7:0] b;

    // Reset state, and a CPU request in IDLE must not start the receiver.
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    s0 = start_cnt;
    cpu_in_req = 1'b1;
    repeat (6) @(negedge clk);
    cpu_in_req = 1'b0;
    check("idle_req_no_start", start_cnt - s0, 0);

    // Basic load.
    set_str("+>a-!");
    do_load("basic");
    check("basic_len3", prog_len, 3);

    // CPU input byte.
    cpu_xfer("cpu41", 8'h41);

    // Overflow: 7 opcodes fill the usable slots, remaining bytes are left in the receiver.
    set_str("++++++++++");
    do_load("ovf");
    check("ovf_flag", overflow, 1);
    check("ovf_len7", prog_len, 7);
    check("ovf_left", rx_q.size() - rx_rd, 3);

    // Pending load raised during a CPU transfer.
    flush_rx();
    b = 8'($urandom_range(255, 0));
    rx_q.push_back(b);
    set_str("[-]>.!");
    push_stream(sstart);
    a0 = ack_cnt;
    base = wr_log.size();
    @(negedge clk); cpu_in_req = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!rx_busy && k < 100);
    check("pend_busy_seen", rx_busy, 1);
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
    wait_ack("pend");
    check("pend_ack_before_load", loading, 0);
    @(negedge clk);
    @(negedge clk);
    check("pend_loading", loading, 1);
    check("pend_ovf_cleared", overflow, 0);
    finish_load("pend", base, sstart);
    check("pend_data", ack_data, b);
    check("pend_nack", ack_cnt - a0, 1);

    // Load and CPU request in the same cycle: load wins, ack only afterwards.
    flush_rx();
    set_str("x<,]!");
    push_stream(sstart);
    b = 8'($urandom_range(255, 0));
    rx_q.push_back(b);
    a0 = ack_cnt;
    base = wr_log.size();
    @(negedge clk); load_start = 1'b1; cpu_in_req = 1'b1;
    @(negedge clk); load_start = 1'b0;
    check("simul_loading", loading, 1);
    finish_load("simul", base, sstart);
    check("simul_no_ack_during_load", ack_cnt - a0, 0);
    wait_ack("simul");
    repeat (3) @(negedge clk);
    check("simul_data", ack_data, b);
    check("simul_nack", ack_cnt - a0, 1);

    // Randomized loads and CPU transfers.
    for (int it = 0; it < 8; it++) begin
      rand_stream();
      do_load($sformatf("rnd%0d", it));
      for (int j = 0; j < int'($urandom_range(2, 1)); j++)
        cpu_xfer($sformatf("rnd%0d_cpu%0d", it, j), 8'($urandom_range(255, 0)));
    end

    // Reset in the middle of a load.
    set_str("++++++!");
    flush_rx();
    push_stream(sstart);
    pulse_load();
    k = 0;
    do begin @(negedge clk); k++; end while (!rx_busy && k < 100);
    @(negedge clk);
    check("midrst_was_loading", loading, 1);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flush_rx();
    s0 = start_cnt;
    cpu_in_req = 1'b1;
    repeat (8) @(negedge clk);
    cpu_in_req = 1'b0;
    check("midrst_no_start", start_cnt - s0, 0);
    check("midrst_ready", prog_ready, 0);

    // Recovery after reset.
    set_str("+>a-!");
    do_load("reload");

    check("rx_never_starved", n_starve, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
